// File: rtl/cpu_control_r_type.sv
// Single-cycle MIPS-subset datapath: PC, instruction memory, register bank, ALU and data memory.
// Executes one R-type or I-type instruction per clock and exposes the ALU result.

module cpu_inst_mem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [5:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] instBank [0:63];

    // Program-load port; unused in normal operation, the top ties it off.
    always_ff @(posedge clk_i) begin
        if (we_i) instBank[addr_i] <= wdata_i;
    end

    assign rdata_o = instBank[addr_i];
endmodule

module cpu_reg_bank (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rda_o,
    output logic [31:0] rdb_o
);
    logic [31:0] registerBank [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) registerBank[wa_i] <= wd_i;
    end

    assign rda_o = (ra_i == 5'd0) ? 32'd0 : registerBank[ra_i];
    assign rdb_o = (rb_i == 5'd0) ? 32'd0 : registerBank[rb_i];
endmodule

module cpu_data_mem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [5:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] dataMemory [0:63];

    always_ff @(posedge clk_i) begin
        if (we_i) dataMemory[addr_i] <= wdata_i;
    end

    assign rdata_o = dataMemory[addr_i];
endmodule

module cpu_control_r_type (
    input  logic        clk_CPU,
    input  logic        rst_CPU,
    output logic [31:0] resultado
);
    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluNor, AluSlt, AluZero} alu_op_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr, rs_data, rt_data, dm_rdata, imm_ext, alu_b, alu_y, wd;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic        reg_we, mem_we, dst_rd, use_imm, imm_zext, mem_to_reg, branch;
    alu_op_e     alu_op;
    logic        unused_shamt;

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        dst_rd     = 1'b0;
        use_imm    = 1'b0;
        imm_zext   = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        alu_op     = AluZero;
        unique case (op)
            6'h00: begin
                dst_rd = 1'b1;
                reg_we = 1'b1;
                unique case (funct)
                    6'h20:   alu_op = AluAdd;
                    6'h22:   alu_op = AluSub;
                    6'h24:   alu_op = AluAnd;
                    6'h25:   alu_op = AluOr;
                    6'h27:   alu_op = AluNor;
                    6'h2A:   alu_op = AluSlt;
                    default: reg_we = 1'b0;
                endcase
            end
            6'h08: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = AluAdd; end
            6'h0C: begin reg_we = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = AluAnd; end
            6'h0D: begin reg_we = 1'b1; use_imm = 1'b1; imm_zext = 1'b1; alu_op = AluOr; end
            6'h0A: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = AluSlt; end
            6'h23: begin reg_we = 1'b1; use_imm = 1'b1; mem_to_reg = 1'b1; alu_op = AluAdd; end
            6'h2B: begin mem_we = 1'b1; use_imm = 1'b1; alu_op = AluAdd; end
            6'h04: begin branch = 1'b1; alu_op = AluSub; end
            default: ;
        endcase
    end

    assign imm_ext = imm_zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};
    assign alu_b   = use_imm ? imm_ext : rt_data;

    always_comb begin
        alu_y = 32'd0;
        unique case (alu_op)
            AluAdd:  alu_y = rs_data + alu_b;
            AluSub:  alu_y = rs_data - alu_b;
            AluAnd:  alu_y = rs_data & alu_b;
            AluOr:   alu_y = rs_data | alu_b;
            AluNor:  alu_y = ~(rs_data | alu_b);
            AluSlt:  alu_y = {31'd0, $signed(rs_data) < $signed(alu_b)};
            default: alu_y = 32'd0;
        endcase
    end

    assign resultado = alu_y;
    assign wa        = dst_rd ? rd : rt;
    assign wd        = mem_to_reg ? dm_rdata : alu_y;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (branch && (alu_y == 32'd0)) pc_d = pc_q + 32'd4 + {imm_ext[29:0], 2'b00};
    end

    always_ff @(posedge clk_CPU) begin
        if (rst_CPU) pc_q <= 32'd0;
        else         pc_q <= pc_d;
    end

    cpu_inst_mem IM (
        .clk_i   (clk_CPU),
        .we_i    (1'b0),
        .addr_i  (pc_q[7:2]),
        .wdata_i (32'd0),
        .rdata_o (instr)
    );

    // Reset cancels the in-flight instruction's writes.
    cpu_reg_bank BR (
        .clk_i (clk_CPU),
        .we_i  (reg_we && !rst_CPU),
        .ra_i  (rs),
        .rb_i  (rt),
        .wa_i  (wa),
        .wd_i  (wd),
        .rda_o (rs_data),
        .rdb_o (rt_data)
    );

    cpu_data_mem DM (
        .clk_i   (clk_CPU),
        .we_i    (mem_we && !rst_CPU),
        .addr_i  (alu_y[7:2]),
        .wdata_i (rt_data),
        .rdata_o (dm_rdata)
    );
endmodule

// File: tb/tb_cpu_control_r_type.sv
// Directed bench for cpu_control_r_type: memories preloaded hierarchically, one task per scenario.

module tb_cpu_control_r_type;
    logic        clk_CPU;
    logic        rst_CPU;
    logic [31:0] resultado;
    int          checks;
    int          errors;

    localparam logic [31:0] Nop = 32'hFC00_0000;

    cpu_control_r_type dut (
        .clk_CPU   (clk_CPU),
        .rst_CPU   (rst_CPU),
        .resultado (resultado)
    );

    initial clk_CPU = 1'b0;
    always #5 clk_CPU = ~clk_CPU;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk_CPU);
        #1;
    endtask

    // Hold reset and clear all three memories; the caller then preloads and calls start().
    task automatic clear_all();
        rst_CPU = 1'b1;
        for (int i = 0; i < 64; i++) dut.IM.instBank[i] <= Nop;
        for (int i = 0; i < 32; i++) dut.BR.registerBank[i] <= 32'd0;
        for (int i = 0; i < 64; i++) dut.DM.dataMemory[i] <= 32'd0;
    endtask

    task automatic start();
        tick();
        rst_CPU = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_all();
        dut.IM.instBank[0] <= i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        dut.IM.instBank[1] <= i_ins(6'h08, 5'd0, 5'd2, 16'd7);
        tick();
        checks++;
        if (dut.pc_q !== 32'd0) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", dut.pc_q, 32'd0);
        end
        checks++;
        if (dut.BR.registerBank[1] !== 32'd0) begin
            errors++; $display("FAIL reset_no_write: got %h expected %h", dut.BR.registerBank[1], 32'd0);
        end
        rst_CPU = 1'b0;
        #1;
        checks++;
        if (resultado !== 32'd5) begin
            errors++; $display("FAIL reset_res0: got %h expected %h", resultado, 32'd5);
        end
        tick();
        checks++;
        if (dut.BR.registerBank[1] !== 32'd5) begin
            errors++; $display("FAIL reset_r1: got %h expected %h", dut.BR.registerBank[1], 32'd5);
        end
        checks++;
        if (dut.pc_q !== 32'd4 || resultado !== 32'd7) begin
            errors++; $display("FAIL reset_step: got pc %h res %h expected pc 4 res 7", dut.pc_q, resultado);
        end
        rst_CPU = 1'b1;
        tick();
        checks++;
        if (dut.BR.registerBank[2] !== 32'd0 || dut.pc_q !== 32'd0) begin
            errors++; $display("FAIL reset_cancel: got r2 %h pc %h expected r2 0 pc 0", dut.BR.registerBank[2], dut.pc_q);
        end
        rst_CPU = 1'b0;
        tick();
        checks++;
        if (dut.pc_q !== 32'd4) begin
            errors++; $display("FAIL reset_restart: got %h expected %h", dut.pc_q, 32'd4);
        end
    endtask

    task automatic test_r_type();
        logic [31:0] exp_res [0:6];
        logic [31:0] exp_reg [0:6];
        exp_res = '{32'd22, 32'd2, 32'd8, 32'd14, 32'd1, 32'hFFFF_FFF1, 32'd0};
        exp_reg = '{32'd22, 32'd2, 32'd8, 32'd14, 32'd1, 32'hFFFF_FFF1, 32'h55};
        clear_all();
        dut.BR.registerBank[2]  <= 32'd12;
        dut.BR.registerBank[3]  <= 32'd10;
        dut.BR.registerBank[10] <= 32'h55;
        dut.IM.instBank[0] <= r_ins(5'd2, 5'd3, 5'd4, 6'h20);
        dut.IM.instBank[1] <= r_ins(5'd2, 5'd3, 5'd5, 6'h22);
        dut.IM.instBank[2] <= r_ins(5'd2, 5'd3, 5'd6, 6'h24);
        dut.IM.instBank[3] <= r_ins(5'd2, 5'd3, 5'd7, 6'h25);
        dut.IM.instBank[4] <= r_ins(5'd3, 5'd2, 5'd8, 6'h2A);
        dut.IM.instBank[5] <= r_ins(5'd2, 5'd3, 5'd9, 6'h27);
        dut.IM.instBank[6] <= r_ins(5'd2, 5'd3, 5'd10, 6'h21);
        start();
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (resultado !== exp_res[i]) begin
                errors++; $display("FAIL rtype_res[%0d]: got %h expected %h", i, resultado, exp_res[i]);
            end
            tick();
            checks++;
            if (dut.BR.registerBank[4 + i] !== exp_reg[i]) begin
                errors++; $display("FAIL rtype_reg[%0d]: got %h expected %h", 4 + i, dut.BR.registerBank[4 + i], exp_reg[i]);
            end
        end
    endtask

    task automatic test_i_type();
        logic [31:0] exp_val [0:3];
        exp_val = '{32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_8000, 32'd1};
        clear_all();
        dut.IM.instBank[0] <= i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF);
        dut.IM.instBank[1] <= i_ins(6'h0C, 5'd1, 5'd2, 16'h00F0);
        dut.IM.instBank[2] <= i_ins(6'h0D, 5'd0, 5'd3, 16'h8000);
        dut.IM.instBank[3] <= i_ins(6'h0A, 5'd1, 5'd4, 16'h0000);
        start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (resultado !== exp_val[i]) begin
                errors++; $display("FAIL itype_res[%0d]: got %h expected %h", i, resultado, exp_val[i]);
            end
            tick();
            checks++;
            if (dut.BR.registerBank[1 + i] !== exp_val[i]) begin
                errors++; $display("FAIL itype_reg[%0d]: got %h expected %h", 1 + i, dut.BR.registerBank[1 + i], exp_val[i]);
            end
        end
    endtask

    task automatic test_memory();
        clear_all();
        dut.DM.dataMemory[1] <= 32'h1234;
        dut.IM.instBank[0] <= i_ins(6'h23, 5'd0, 5'd5, 16'h0004);
        dut.IM.instBank[1] <= i_ins(6'h2B, 5'd0, 5'd5, 16'h0008);
        dut.IM.instBank[2] <= i_ins(6'h23, 5'd0, 5'd6, 16'h0008);
        dut.IM.instBank[3] <= i_ins(6'h23, 5'd0, 5'd7, 16'h0104);
        start();
        checks++;
        if (resultado !== 32'd4) begin
            errors++; $display("FAIL mem_lw_addr: got %h expected %h", resultado, 32'd4);
        end
        tick();
        checks++;
        if (dut.BR.registerBank[5] !== 32'h1234) begin
            errors++; $display("FAIL mem_lw_data: got %h expected %h", dut.BR.registerBank[5], 32'h1234);
        end
        checks++;
        if (resultado !== 32'd8) begin
            errors++; $display("FAIL mem_sw_addr: got %h expected %h", resultado, 32'd8);
        end
        tick();
        checks++;
        if (dut.DM.dataMemory[2] !== 32'h1234) begin
            errors++; $display("FAIL mem_sw_data: got %h expected %h", dut.DM.dataMemory[2], 32'h1234);
        end
        checks++;
        if (resultado !== 32'd8) begin
            errors++; $display("FAIL mem_lw2_addr: got %h expected %h", resultado, 32'd8);
        end
        tick();
        checks++;
        if (dut.BR.registerBank[6] !== 32'h1234) begin
            errors++; $display("FAIL mem_lw2_data: got %h expected %h", dut.BR.registerBank[6], 32'h1234);
        end
        checks++;
        if (resultado !== 32'h104) begin
            errors++; $display("FAIL mem_wrap_addr: got %h expected %h", resultado, 32'h104);
        end
        tick();
        checks++;
        if (dut.BR.registerBank[7] !== 32'h1234) begin
            errors++; $display("FAIL mem_wrap_data: got %h expected %h", dut.BR.registerBank[7], 32'h1234);
        end
    endtask

    task automatic test_branch();
        clear_all();
        dut.BR.registerBank[1] <= 32'd7;
        dut.BR.registerBank[2] <= 32'd7;
        dut.IM.instBank[0] <= i_ins(6'h04, 5'd1, 5'd2, 16'd2);
        dut.IM.instBank[3] <= i_ins(6'h04, 5'd0, 5'd0, 16'hFFFD);
        start();
        checks++;
        if (resultado !== 32'd0) begin
            errors++; $display("FAIL beq_res: got %h expected %h", resultado, 32'd0);
        end
        tick();
        checks++;
        if (dut.pc_q !== 32'd12) begin
            errors++; $display("FAIL beq_taken: got %h expected %h", dut.pc_q, 32'd12);
        end
        tick();
        checks++;
        if (dut.pc_q !== 32'd4) begin
            errors++; $display("FAIL beq_back: got %h expected %h", dut.pc_q, 32'd4);
        end
        clear_all();
        dut.BR.registerBank[1] <= 32'd7;
        dut.BR.registerBank[2] <= 32'd8;
        dut.IM.instBank[0] <= i_ins(6'h04, 5'd1, 5'd2, 16'd2);
        start();
        checks++;
        if (resultado !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL bne_res: got %h expected %h", resultado, 32'hFFFF_FFFF);
        end
        tick();
        checks++;
        if (dut.pc_q !== 32'd4) begin
            errors++; $display("FAIL beq_not_taken: got %h expected %h", dut.pc_q, 32'd4);
        end
        clear_all();
        dut.BR.registerBank[1] <= 32'd7;
        dut.BR.registerBank[2] <= 32'd7;
        dut.IM.instBank[0] <= i_ins(6'h04, 5'd1, 5'd2, 16'd2);
        start();
        rst_CPU = 1'b1;
        tick();
        checks++;
        if (dut.pc_q !== 32'd0) begin
            errors++; $display("FAIL beq_reset_prio: got %h expected %h", dut.pc_q, 32'd0);
        end
        rst_CPU = 1'b0;
    endtask

    task automatic test_reg0_unknown();
        clear_all();
        dut.BR.registerBank[1] <= 32'h77;
        dut.DM.dataMemory[1]   <= 32'hABCD;
        dut.IM.instBank[0] <= i_ins(6'h08, 5'd0, 5'd0, 16'd9);
        dut.IM.instBank[1] <= {6'h3F, 5'd1, 5'd1, 16'h0004};
        dut.IM.instBank[2] <= r_ins(5'd0, 5'd1, 5'd3, 6'h20);
        start();
        checks++;
        if (resultado !== 32'd9) begin
            errors++; $display("FAIL r0_addi_res: got %h expected %h", resultado, 32'd9);
        end
        tick();
        tick();
        checks++;
        if (dut.pc_q !== 32'd8) begin
            errors++; $display("FAIL unk_pc: got %h expected %h", dut.pc_q, 32'd8);
        end
        checks++;
        if (dut.BR.registerBank[1] !== 32'h77 || dut.DM.dataMemory[1] !== 32'hABCD) begin
            errors++; $display("FAIL unk_nowrite: got r1 %h dm1 %h expected r1 77 dm1 abcd", dut.BR.registerBank[1], dut.DM.dataMemory[1]);
        end
        checks++;
        if (resultado !== 32'h77) begin
            errors++; $display("FAIL r0_reads_zero: got %h expected %h", resultado, 32'h77);
        end
        tick();
        checks++;
        if (dut.BR.registerBank[3] !== 32'h77) begin
            errors++; $display("FAIL r0_add_dst: got %h expected %h", dut.BR.registerBank[3], 32'h77);
        end
    endtask

    task automatic test_index_wrap();
        clear_all();
        dut.IM.instBank[0] <= i_ins(6'h08, 5'd1, 5'd1, 16'd1);
        start();
        for (int i = 0; i < 64; i++) tick();
        checks++;
        if (dut.pc_q !== 32'd256 || dut.BR.registerBank[1] !== 32'd1) begin
            errors++; $display("FAIL wrap_state: got pc %h r1 %h expected pc 100 r1 1", dut.pc_q, dut.BR.registerBank[1]);
        end
        checks++;
        if (resultado !== 32'd2) begin
            errors++; $display("FAIL wrap_res: got %h expected %h", resultado, 32'd2);
        end
        tick();
        checks++;
        if (dut.BR.registerBank[1] !== 32'd2) begin
            errors++; $display("FAIL wrap_r1: got %h expected %h", dut.BR.registerBank[1], 32'd2);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_CPU = 1'b1;
        test_reset();
        test_r_type();
        test_i_type();
        test_memory();
        test_branch();
        test_reg0_unknown();
        test_index_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
